// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite to APB bridge: one outstanding transfer, NUM_SLAVES equal-sized windows, pready watchdog.
// Define BRIDGE_ERRRESP_EN to turn decode misses, pslverr and watchdog expiry into a two-cycle AHB ERROR.
module ahb_apb_bridge_mslv #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLAVES = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000),
    parameter int                SLV_SHIFT  = 26,
    parameter int                TIMEOUT    = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_W-1:0]     HADDR,
    input  logic [DATA_W-1:0]     HWDATA,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  hready_out,
    output logic [1:0]            hresp,
    output logic [DATA_W-1:0]     hrdata,
    output logic [ADDR_W-1:0]     paddr,
    output logic                  pwrite,
    output logic [DATA_W-1:0]     pwdata,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [2:0]            dbg_state
);
`ifdef BRIDGE_ERRRESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPT, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  offset, slot;
    logic               hit, accept, expire;
    logic               unused_ok;

    assign unused_ok = HTRANS[0];

    // Comparing the whole shifted offset keeps the decode exact: no aliasing above the last slave.
    assign offset = HADDR - BASE_ADDR;
    assign slot   = offset >> SLV_SHIFT;
    assign hit    = (HADDR >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLAVES));
    assign accept = (state == S_IDLE || state == S_DONE || state == S_ERR2) && HREADY && HTRANS[1];
    // cnt holds the number of ACCESS cycles already spent, so this fires on the TIMEOUT-th one.
    assign expire = (TIMEOUT != 0) && (state == S_ACCESS) && !pready && (cnt == CNT_LAST);

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (!accept)     state_nxt = S_IDLE;
                else if (!hit)   state_nxt = ERR_EN ? S_ERR1 : S_DONE;
                else if (HWRITE) state_nxt = S_CAPT;
                else             state_nxt = S_SETUP;
            end
            S_CAPT:   state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (pready)      state_nxt = (ERR_EN && pslverr) ? S_ERR1 : S_DONE;
                else if (expire) state_nxt = ERR_EN ? S_ERR1 : S_DONE;
            end
            S_ERR1:   state_nxt = S_ERR2;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign hready_out = !(state == S_CAPT || state == S_SETUP || state == S_ACCESS || state == S_ERR1);
    assign hresp      = (ERR_EN && (state == S_ERR1 || state == S_ERR2)) ? 2'b01 : 2'b00;
    assign psel       = (state == S_SETUP || state == S_ACCESS) ? (NUM_SLAVES'(1) << idx) : '0;
    assign penable    = (state == S_ACCESS);
    assign dbg_state  = state;

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            hrdata <= '0;
            idx    <= '0;
            cnt    <= '0;
        end else begin
            // Only hits update the APB address side, so a miss leaves the previous cycle visible.
            if (accept && hit) begin
                paddr  <= HADDR;
                pwrite <= HWRITE;
                idx    <= slot[IDX_W-1:0];
            end
            if (!ERR_EN && accept && !hit && !HWRITE) hrdata <= '0;
            if (state == S_CAPT) pwdata <= HWDATA;
            if (state == S_SETUP)                        cnt <= '0;
            else if (state == S_ACCESS && cnt != '1)     cnt <= cnt + CNT_W'(1);
            if (state == S_ACCESS && !pwrite) begin
                if (pready && !(ERR_EN && pslverr)) hrdata <= prdata;
                else if (!ERR_EN && expire)         hrdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Randomized bench for ahb_apb_bridge_mslv: per-transfer expectations come from the address map
// and wait-state arithmetic, with an expected-hrdata queue as scoreboard.
module tb_ahb_apb_bridge_mslv;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          SHIFT = 26;
    localparam int          NSLV  = 4;
    localparam int          TMO   = 16;
    localparam logic [1:0]  H_IDLE = 2'b00, H_BUSY = 2'b01, H_NONSEQ = 2'b10, H_SEQ = 2'b11;
`ifdef BRIDGE_ERRRESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        HCLK, HRESET;
    logic [31:0] HADDR, HWDATA;
    logic        HWRITE, HREADY;
    logic [1:0]  HTRANS;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata, paddr, pwdata, prdata;
    logic        pwrite, penable, pready, pslverr;
    logic [3:0]  psel;
    logic [2:0]  dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_rd;

    // Clock and reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_apb_bridge_mslv #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(NSLV), .BASE_ADDR(BASE),
        .SLV_SHIFT(SHIFT), .TIMEOUT(TMO)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HREADY(HREADY), .hready_out(hready_out), .hresp(hresp),
        .hrdata(hrdata), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel),
        .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hready"}, 32'(hready_out), 32'd1);
        check({tag, "_hresp"}, 32'(hresp), 32'd0);
        check({tag, "_hrdata"}, hrdata, 32'd0);
        check({tag, "_paddr"}, paddr, 32'd0);
        check({tag, "_pwrite"}, 32'(pwrite), 32'd0);
        check({tag, "_pwdata"}, pwdata, 32'd0);
        check({tag, "_psel"}, 32'(psel), 32'd0);
        check({tag, "_penable"}, 32'(penable), 32'd0);
    endtask

    // One non-accepted cycle: IDLE/BUSY, or NONSEQ with HREADY low.
    task automatic idle_cycle();
        int mode;
        mode   = $urandom_range(0, 2);
        HADDR  = BASE + 32'($urandom_range(0, 255)) * 4;
        HWRITE = 1'($urandom_range(0, 1));
        case (mode)
            0:       begin HTRANS = H_IDLE;   HREADY = 1'($urandom_range(0, 1)); end
            1:       begin HTRANS = H_BUSY;   HREADY = 1'($urandom_range(0, 1)); end
            default: begin HTRANS = H_NONSEQ; HREADY = 1'b0; end
        endcase
        @(posedge HCLK); #1;
        check("idle_hready", 32'(hready_out), 32'd1);
        check("idle_hresp", 32'(hresp), 32'd0);
        check("idle_psel", 32'(psel), 32'd0);
        check("idle_penable", 32'(penable), 32'd0);
        HTRANS = H_IDLE;
        HREADY = 1'b1;
    endtask

    // Drives one AHB transfer and plays the APB slave (nwait low-pready ACCESS cycles).
    task automatic run_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                            input int nwait, input bit serr, input logic [31:0] rdata);
        bit          hit, tmo, err, done;
        int          slot, acc_exp, ws_exp, cyc, acc, setups, ws;
        logic [31:0] old_rd, new_rd, psel_seen;

        hit     = (addr >= BASE) && (((addr - BASE) >> SHIFT) < NSLV);
        slot    = hit ? int'((addr - BASE) >> SHIFT) : 0;
        tmo     = hit && (nwait >= TMO);
        err     = ERR_EN && (!hit || tmo || serr);
        acc_exp = !hit ? 0 : (tmo ? TMO : nwait + 1);
        ws_exp  = hit ? (int'(wr) + 1 + acc_exp + int'(err)) : int'(err);
        old_rd  = exp_rd;
        if (wr)                                          new_rd = old_rd;
        else if (hit && !tmo && !(ERR_EN && serr))       new_rd = rdata;
        else if (ERR_EN)                                 new_rd = old_rd;
        else                                             new_rd = 32'h0;
        exp_rd = new_rd;
        exp_q.push_back(new_rd);

        HADDR   = addr;
        HWRITE  = wr;
        HTRANS  = ($urandom_range(0, 1) == 1) ? H_NONSEQ : H_SEQ;
        HREADY  = 1'b1;
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;

        cyc = 0; acc = 0; setups = 0; ws = 0; psel_seen = 0; done = 0;
        while (!done && cyc < 64) begin
            @(posedge HCLK); #1;
            cyc++;
            if (cyc == 1) begin
                HTRANS = H_IDLE;
                HWDATA = wr ? wdata : $urandom;
            end
            if (psel != '0) begin
                psel_seen |= 32'(psel);
                check("paddr", paddr, addr);
                check("pwrite", 32'(pwrite), 32'(wr));
                if (penable) begin
                    acc++;
                    if (wr) check("pwdata", pwdata, wdata);
                end else begin
                    setups++;
                end
            end
            if (hready_out) begin
                done = 1;
                check("wait_states", ws, ws_exp);
                check("hresp_end", 32'(hresp), err ? 32'd1 : 32'd0);
                check("hrdata_end", hrdata, exp_q.pop_front());
                check("apb_access", acc, acc_exp);
                check("apb_setup", setups, hit ? 32'd1 : 32'd0);
                check("psel_onehot", psel_seen, hit ? (32'd1 << slot) : 32'd0);
            end else begin
                ws++;
                check("hresp_wait", 32'(hresp), (err && ws == ws_exp) ? 32'd1 : 32'd0);
                check("hrdata_hold", hrdata, old_rd);
            end
            if (psel != '0 && penable) begin
                pready  = (acc > nwait);
                prdata  = pready ? rdata : $urandom;
                pslverr = pready ? serr : 1'($urandom_range(0, 1));
            end else begin
                pready  = 1'($urandom_range(0, 1));
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
        end
        if (!done) begin
            check("xfer_done", 32'(done), 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    // Assert reset asynchronously in the middle of an ACCESS phase.
    task automatic reset_mid();
        int k;
        HADDR  = 32'h8400_0040;
        HWRITE = 1'b0;
        HTRANS = H_NONSEQ;
        HREADY = 1'b1;
        pready = 1'b0;
        k = 0;
        do begin
            @(posedge HCLK); #1;
            HTRANS = H_IDLE;
            pready = 1'b0;
            k++;
        end while (!penable && k < 8);
        check("rst_in_access", 32'(penable), 32'd1);
        #2 HRESET = 1'b0;
        #1;
        check_reset_values("rst_async");
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        exp_rd = 32'h0;
        exp_q.delete();
        @(posedge HCLK); #1;
        check_reset_values("rst_release");
    endtask

    initial begin
        logic [31:0] addr;
        int          nwait;
        HRESET = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HTRANS = H_IDLE; HREADY = 1'b1;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        exp_rd = 32'h0;
        #3;
        check_reset_values("reset");
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;

        // Directed cases from the address map and wait-state rules
        run_xfer(32'h8000_0010, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
        idle_cycle();
        run_xfer(32'h8800_0004, 1'b1, 32'h1234_5678, 2, 1'b0, 32'h0);
        run_xfer(32'h8400_0000, 1'b0, 32'h0, 0, 1'b1, 32'h5555_AAAA);
        run_xfer(32'h7000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_2222);
        run_xfer(32'h9000_0000, 1'b1, 32'hFEED_0001, 0, 1'b0, 32'h0);
        run_xfer(32'h8000_0100, 1'b0, 32'h0, 20, 1'b0, 32'h3333_4444);
        run_xfer(32'h8000_0200, 1'b0, 32'h0, 15, 1'b0, 32'h7777_8888);
        idle_cycle();
        run_xfer(32'h8000_0000, 1'b1, 32'hA5A5_5A5A, 0, 1'b0, 32'h0);
        run_xfer(32'h8C00_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0:       addr = $urandom;
                1:       addr = 32'h7FFF_F000 + 32'($urandom_range(0, 1023)) * 4;
                5:       addr = 32'h9000_0000 + 32'($urandom_range(0, 65535)) * 4;
                default: addr = BASE + (32'($urandom_range(0, NSLV - 1)) << SHIFT)
                                + 32'($urandom_range(0, 65535)) * 4;
            endcase
            nwait = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3);
            run_xfer(addr, 1'($urandom_range(0, 1)), $urandom, nwait,
                     ($urandom_range(0, 3) == 0), $urandom);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        reset_mid();
        run_xfer(32'h8000_0010, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
